a2d_scan_intf: RTL and testbench

Parametrised scanning interface to the ADC128S 8-channel SPI A2D converter. It generalises the fixed three-channel round-robin A2D interface to 1–8 mapped channels. Commands are pipelined so a scan of N channels costs N+1 SPI transactions instead of 2N, and results can optionally be averaged over 2^AVG_LOG2 scans. It sits between the Segway control logic (load cells, battery) and the A2D pins, and offers single-shot and continuous scan modes.

---
 rtl/a2d_pkg.sv | 21 ++
 rtl/a2d_spi_xfer.sv | 119 +++++++++++
 rtl/a2d_scan_intf.sv | 128 ++++++++++++
 tb/tb_a2d_scan_intf.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// Shared types and helpers for the ADC128S scanning interface.
package a2d_pkg;

   localparam int unsigned CH_W  = 3;
   localparam int unsigned CMD_W = 16;

   // Transaction phases of the SPI engine.
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FRONT = 3'd1,
      SHIFT = 3'd2,
      BACK  = 3'd3,
      GAP   = 3'd4
   } a2d_state_e;

   // ADC128S control word: channel address sits in bits [13:11].
   function automatic logic [CMD_W-1:0] mk_cmd(input logic [CH_W-1:0] ch);
      return {2'b00, ch, 11'h000};
   endfunction

endpackage

// File: rtl/a2d_spi_xfer.sv
// Single 16-bit SPI transaction engine for the ADC128S (SCLK idles high).
// One transaction is 17*SCLK_DIV clocks: a half-bit FRONT, 16 bits,
// then SS_n high for a half-bit GAP. The high half of the last bit is the
// BACK phase, so BACK does not add time on top of the 16 bits.
module a2d_spi_xfer
   import a2d_pkg::*;
#(
   parameter int unsigned SCLK_DIV = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             go,
   input  logic [CMD_W-1:0] tx,
   output logic [CMD_W-1:0] rx,
   output logic             xfer_done,
   output logic             SS_n,
   output logic             SCLK,
   output logic             MOSI,
   input  logic             MISO
);

   localparam int unsigned HALF = SCLK_DIV / 2;
   localparam int unsigned CW   = $clog2(SCLK_DIV);
   localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
   localparam logic [CW-1:0] FULL_M1 = CW'(SCLK_DIV - 1);

   a2d_state_e       state;
   logic [CW-1:0]    cnt;
   logic [3:0]       bit_idx;
   logic [CMD_W-1:0] sh;

   // Last GAP cycle: a pending go chains straight into the next FRONT.
   assign xfer_done = (state == GAP) && (cnt == HALF_M1);

   // Phase sequencer; SCLK/SS_n/MOSI are registered so they never glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         sh      <= '0;
         rx      <= '0;
         SS_n    <= 1'b1;
         SCLK    <= 1'b1;
         MOSI    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (go) begin
                  state <= FRONT;
                  cnt   <= '0;
                  sh    <= tx;
                  SS_n  <= 1'b0;
                  SCLK  <= 1'b1;
               end
            end
            FRONT: begin
               if (cnt == HALF_M1) begin
                  state   <= SHIFT;
                  cnt     <= '0;
                  bit_idx <= '0;
                  SCLK    <= 1'b0;
                  MOSI    <= sh[CMD_W-1];
                  sh      <= {sh[CMD_W-2:0], 1'b0};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            SHIFT: begin
               if (cnt == HALF_M1) begin
                  SCLK <= 1'b1;
                  rx   <= {rx[CMD_W-2:0], MISO};
                  if (bit_idx == 4'd15) begin
                     state <= BACK;
                     cnt   <= '0;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end else if (cnt == FULL_M1) begin
                  cnt     <= '0;
                  bit_idx <= bit_idx + 1'b1;
                  SCLK    <= 1'b0;
                  MOSI    <= sh[CMD_W-1];
                  sh      <= {sh[CMD_W-2:0], 1'b0};
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            BACK: begin
               if (cnt == HALF_M1) begin
                  state <= GAP;
                  cnt   <= '0;
                  SS_n  <= 1'b1;
                  MOSI  <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            GAP: begin
               if (cnt == HALF_M1) begin
                  cnt <= '0;
                  if (go) begin
                     state <= FRONT;
                     sh    <= tx;
                     SS_n  <= 1'b0;
                     SCLK  <= 1'b1;
                  end else begin
                     state <= IDLE;
                  end
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/a2d_scan_intf.sv
// Scanning front end for the ADC128S: pipelines channel commands so a scan
// of NUM_CH slots takes NUM_CH+1 transactions, and optionally averages
// results over 2^AVG_LOG2 scans.
module a2d_scan_intf
   import a2d_pkg::*;
#(
   parameter int unsigned                NUM_CH   = 3,
   parameter logic [NUM_CH*CH_W-1:0]     CH_MAP   = {3'd5, 3'd4, 3'd0},
   parameter int unsigned                SCLK_DIV = 32,
   parameter int unsigned                DATA_W   = 12,
   parameter int unsigned                AVG_LOG2 = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       cont_en,
   output logic                       busy,
   output logic                       done,
   output logic [NUM_CH*DATA_W-1:0]   res,
   output logic                       res_vld,
   output logic                       SS_n,
   output logic                       SCLK,
   output logic                       MOSI,
   input  logic                       MISO
);

   localparam int unsigned AW     = DATA_W + AVG_LOG2;
   localparam int unsigned NSCAN  = 1 << AVG_LOG2;
   localparam logic [3:0]  LAST_T = 4'(NUM_CH);
   localparam logic [3:0]  AVG_M1 = 4'(NSCAN - 1);

   logic             go;
   logic             go_pend;
   logic             xfer_done;
   logic [CMD_W-1:0] tx;
   logic [CMD_W-1:0] rx;
   logic [3:0]       t;
   logic [3:0]       tn;
   logic [CH_W-1:0]  slot;
   logic [3:0]       scan_cnt;
   logic             scan_end;
   logic             more;
   logic             avg_last;
   logic [AW-1:0]    acc    [NUM_CH];
   logic [AW-1:0]    acc_nx [NUM_CH];

   a2d_spi_xfer #(
      .SCLK_DIV(SCLK_DIV)
   ) u_xfer (
      .clk      (clk),
      .rst      (rst),
      .go       (go),
      .tx       (tx),
      .rx       (rx),
      .xfer_done(xfer_done),
      .SS_n     (SS_n),
      .SCLK     (SCLK),
      .MOSI     (MOSI),
      .MISO     (MISO)
   );

   generate
      if (DATA_W < CMD_W) begin : g_rx_hi
         logic unused_rx_hi;
         assign unused_rx_hi = ^rx[CMD_W-1:DATA_W];
      end
   endgenerate

   // Next-transaction selection, command word and accumulator next-values.
   // The command sent during transaction t names slot t (last slot repeated
   // on the final one), while the response carries slot t-1's sample.
   always_comb begin
      tn       = go_pend ? 4'd0 : ((t == LAST_T) ? 4'd0 : t + 4'd1);
      slot     = (tn >= LAST_T) ? CH_W'(NUM_CH - 1) : tn[CH_W-1:0];
      tx       = mk_cmd(CH_MAP[CH_W*slot +: CH_W]);
      scan_end = xfer_done && (t == LAST_T);
      more     = (t != LAST_T) || cont_en;
      go       = go_pend || (xfer_done && more);
      avg_last = (scan_cnt == AVG_M1);
      for (int unsigned k = 0; k < NUM_CH; k++) begin
         acc_nx[k] = acc[k];
         if (xfer_done && (t == 4'(k + 1)))
            acc_nx[k] = acc[k] + AW'(rx[DATA_W-1:0]);
      end
   end

   // Scan control, accumulation and result publication.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         busy     <= 1'b0;
         go_pend  <= 1'b0;
         t        <= '0;
         scan_cnt <= '0;
         done     <= 1'b0;
         res      <= '0;
         res_vld  <= 1'b0;
         for (int unsigned k = 0; k < NUM_CH; k++) acc[k] <= '0;
      end else begin
         done    <= 1'b0;
         go_pend <= 1'b0;
         if (!busy) begin
            if (start || cont_en) begin
               busy    <= 1'b1;
               go_pend <= 1'b1;
               t       <= '0;
            end
         end else if (xfer_done) begin
            t <= tn;
            for (int unsigned k = 0; k < NUM_CH; k++) acc[k] <= acc_nx[k];
            if (scan_end) begin
               if (!cont_en) busy <= 1'b0;
               if (avg_last) begin
                  scan_cnt <= '0;
                  done     <= 1'b1;
                  res_vld  <= 1'b1;
                  for (int unsigned k = 0; k < NUM_CH; k++) begin
                     acc[k]                   <= '0;
                     res[k*DATA_W +: DATA_W]  <= DATA_W'(acc_nx[k] >> AVG_LOG2);
                  end
               end else begin
                  scan_cnt <= scan_cnt + 4'd1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_a2d_scan_intf.sv
// Bench for a2d_scan_intf: three instances (default, single slot, 4x average)
// each talking to a behavioural ADC128S model.
module tb_a2d_scan_intf;

   localparam int D = 32;
   localparam int T = 17 * D;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [2:0]  rst_v, start_v, cont_v;
   wire  [2:0]  busy_v, done_v, vld_v, ss_n_v, sclk_v, mosi_v, miso_v;
   wire  [35:0] res_a, res_c;
   wire  [11:0] res_b;

   logic [11:0] adc_val [3][8];
   int total = 0;
   int bad   = 0;
   int map3 [3] = '{0, 4, 5};

   a2d_scan_intf #(.NUM_CH(3), .CH_MAP({3'd5, 3'd4, 3'd0}), .SCLK_DIV(D), .DATA_W(12), .AVG_LOG2(0)) dut_a (
      .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .cont_en(cont_v[0]), .busy(busy_v[0]),
      .done(done_v[0]), .res(res_a), .res_vld(vld_v[0]), .SS_n(ss_n_v[0]), .SCLK(sclk_v[0]),
      .MOSI(mosi_v[0]), .MISO(miso_v[0]));

   a2d_scan_intf #(.NUM_CH(1), .CH_MAP(3'd7), .SCLK_DIV(D), .DATA_W(12), .AVG_LOG2(0)) dut_b (
      .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .cont_en(cont_v[1]), .busy(busy_v[1]),
      .done(done_v[1]), .res(res_b), .res_vld(vld_v[1]), .SS_n(ss_n_v[1]), .SCLK(sclk_v[1]),
      .MOSI(mosi_v[1]), .MISO(miso_v[1]));

   a2d_scan_intf #(.NUM_CH(3), .CH_MAP({3'd5, 3'd4, 3'd0}), .SCLK_DIV(D), .DATA_W(12), .AVG_LOG2(2)) dut_c (
      .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .cont_en(cont_v[2]), .busy(busy_v[2]),
      .done(done_v[2]), .res(res_c), .res_vld(vld_v[2]), .SS_n(ss_n_v[2]), .SCLK(sclk_v[2]),
      .MOSI(mosi_v[2]), .MISO(miso_v[2]));

   // ADC128S model: answers each transaction with the channel addressed by
   // the previous one; 4 leading zeros then 12 data bits, shifted on SCLK fall.
   for (genvar g = 0; g < 3; g++) begin : adc
      int          wins   = 0;
      logic [15:0] word   = '0;
      logic [15:0] cmd    = '0;
      logic [2:0]  prev   = '0;
      logic        miso_r = 1'b0;
      assign miso_v[g] = miso_r;
      always @(negedge ss_n_v[g]) begin
         wins++;
         word = {4'h0, adc_val[g][prev]};
         for (int b = 0; b < 16; b++) begin
            @(negedge sclk_v[g] or posedge ss_n_v[g]);
            if (ss_n_v[g]) break;
            miso_r = word[15-b];
            @(posedge sclk_v[g] or posedge ss_n_v[g]);
            if (ss_n_v[g]) break;
            cmd = {cmd[14:0], mosi_v[g]};
         end
         if (!ss_n_v[g]) @(posedge ss_n_v[g]);
         prev = cmd[13:11];
      end
   end

   function automatic int wins_of(input int g);
      case (g)
         0:       return adc[0].wins;
         1:       return adc[1].wins;
         default: return adc[2].wins;
      endcase
   endfunction

   // Expected 3-slot result from current model values and slot map.
   function automatic logic [35:0] exp_res3(input int g);
      logic [35:0] r = '0;
      for (int k = 0; k < 3; k++) r[12*k +: 12] = adc_val[g][map3[k]];
      return r;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Pulse start on instance g and follow it until busy drops.
   task automatic run_scan(input int g, output int lat, output bit saw_done,
                           output int nw, output int ssfall);
      int w0, k;
      w0 = wins_of(g); saw_done = 1'b0; ssfall = -1;
      start_v[g] = 1'b1;
      @(negedge clk);
      start_v[g] = 1'b0;
      k = 1;
      while (k < 20000) begin
         if (done_v[g]) saw_done = 1'b1;
         if (!ss_n_v[g] && ssfall < 0) ssfall = k - 1;
         if (!busy_v[g]) break;
         @(negedge clk);
         k++;
      end
      chk("scan_bound", (k < 20000), 1);
      lat = k - 1;
      nw  = wins_of(g) - w0;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, nw, sf, k, nd, w0;
      bit sd, idle_seen;
      int dc [3];
      int sum [3];
      logic [35:0] er;

      rst_v = '1; start_v = '0; cont_v = '0;
      for (int g = 0; g < 3; g++)
         for (int c = 0; c < 8; c++) adc_val[g][c] = '0;
      repeat (3) @(negedge clk);
      chk("rst_ssn", ss_n_v, 3'b111);
      chk("rst_sclk", sclk_v, 3'b111);
      chk("rst_mosi", mosi_v, 3'b000);
      chk("rst_busy", busy_v, 3'b000);
      chk("rst_done", done_v, 3'b000);
      chk("rst_vld", vld_v, 3'b000);
      chk("rst_res", {res_a, res_b, res_c}, 0);
      rst_v = '0;
      @(negedge clk);

      // single scan, default parameters
      adc_val[0][0] = 12'h001; adc_val[0][4] = 12'h005; adc_val[0][5] = 12'h015;
      run_scan(0, lat, sd, nw, sf);
      chk("a_ssn_fall", sf, 1);
      chk("a_lat", lat, 2177);
      chk("a_done", sd, 1);
      chk("a_wins", nw, 4);
      chk("a_res", res_a, 36'h015_005_001);
      chk("a_vld", vld_v[0], 1);

      // continuous mode, three scans; cont_en drops early in the third
      adc_val[0][0] = 12'h018; adc_val[0][4] = 12'h0FF; adc_val[0][5] = 12'h123;
      w0 = wins_of(0); k = 0; nd = 0; idle_seen = 1'b0;
      cont_v[0] = 1'b1;
      while (nd < 3 && k < 30000) begin
         @(negedge clk);
         k++;
         if (done_v[0]) begin
            dc[nd] = k;
            nd++;
            chk("c_res", res_a, 36'h123_0FF_018);
            if (nd == 2) cont_v[0] = 1'b0;
            if (nd == 3) chk("c_busy_end", busy_v[0], 0);
         end else if (nd >= 1 && !busy_v[0]) begin
            idle_seen = 1'b1;
         end
      end
      cont_v[0] = 1'b0;
      chk("c_ndone", nd, 3);
      chk("c_first_lat", dc[0] - 1, 1 + 4 * T);
      chk("c_gap12", dc[1] - dc[0], 4 * T);
      chk("c_gap23", dc[2] - dc[1], 4 * T);
      chk("c_no_idle", idle_seen, 0);
      repeat (2 * T) @(negedge clk);
      chk("c_stopped", busy_v[0], 0);
      chk("c_wins", wins_of(0) - w0, 12);

      // randomized single scans
      for (int r = 0; r < 3; r++) begin
         for (int c = 0; c < 8; c++) adc_val[0][c] = 12'($urandom_range(0, 4095));
         run_scan(0, lat, sd, nw, sf);
         chk("rnd_lat", lat, 1 + 4 * T);
         chk("rnd_res", res_a, exp_res3(0));
      end

      // start while busy is ignored
      w0 = wins_of(0); nd = 0;
      start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
      repeat (1000) @(negedge clk);
      chk("i_busy_mid", busy_v[0], 1);
      start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
      for (int i = 0; i < 9 * T; i++) begin
         @(negedge clk);
         if (done_v[0]) nd++;
      end
      chk("i_ndone", nd, 1);
      chk("i_wins", wins_of(0) - w0, 4);

      // reset during SHIFT of transaction 2
      w0 = wins_of(0);
      start_v[0] = 1'b1; @(negedge clk); start_v[0] = 1'b0;
      for (int i = 0; i < 5000 && (wins_of(0) - w0) < 3; i++) @(negedge clk);
      chk("r_in_txn2", wins_of(0) - w0, 3);
      repeat (100) @(negedge clk);
      for (int i = 0; i < 100 && sclk_v[0]; i++) @(negedge clk);
      chk("r_sclk_low", sclk_v[0], 0);
      rst_v[0] = 1'b1;
      #1;
      chk("r_ssn", ss_n_v[0], 1);
      chk("r_sclk", sclk_v[0], 1);
      chk("r_mosi", mosi_v[0], 0);
      chk("r_busy", busy_v[0], 0);
      chk("r_res", res_a, 0);
      chk("r_vld", vld_v[0], 0);
      @(negedge clk);
      rst_v[0] = 1'b0;
      @(negedge clk);
      for (int c = 0; c < 8; c++) adc_val[0][c] = 12'($urandom_range(0, 4095));
      run_scan(0, lat, sd, nw, sf);
      chk("r2_lat", lat, 1 + 4 * T);
      chk("r2_wins", nw, 4);
      chk("r2_res", res_a, exp_res3(0));

      // single slot mapped to channel 7
      adc_val[1][7] = 12'hABC;
      run_scan(1, lat, sd, nw, sf);
      chk("b_lat", lat, 1 + 2 * T);
      chk("b_wins", nw, 2);
      chk("b_res", res_b, 12'hABC);
      adc_val[1][7] = 12'($urandom_range(0, 4095));
      run_scan(1, lat, sd, nw, sf);
      chk("b_rnd_res", res_b, adc_val[1][7]);

      // averaging over four scans, directed then randomized
      adc_val[2][4] = 12'h010; adc_val[2][5] = 12'h020;
      for (int s = 0; s < 4; s++) begin
         adc_val[2][0] = 12'h100 + 12'(4 * s);
         run_scan(2, lat, sd, nw, sf);
         if (s < 3) begin
            chk("v_no_done", sd, 0);
            chk("v_vld_low", vld_v[2], 0);
         end
      end
      chk("v_done", sd, 1);
      chk("v_res", res_c, 36'h020_010_106);
      chk("v_vld", vld_v[2], 1);
      for (int k2 = 0; k2 < 3; k2++) sum[k2] = 0;
      for (int s = 0; s < 4; s++) begin
         for (int c = 0; c < 8; c++) adc_val[2][c] = 12'($urandom_range(0, 4095));
         for (int k2 = 0; k2 < 3; k2++) sum[k2] += int'(adc_val[2][map3[k2]]);
         run_scan(2, lat, sd, nw, sf);
         if (s < 3) chk("vr_no_done", sd, 0);
      end
      er = '0;
      for (int k2 = 0; k2 < 3; k2++) er[12*k2 +: 12] = 12'(sum[k2] / 4);
      chk("vr_done", sd, 1);
      chk("vr_res", res_c, er);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
